// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side blocks: FSM encoding, command bytes, parity.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RTS,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_ACK          = 8'hFA;

    // Odd parity: the nine bits {parity, byte} always carry an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Glitch filter for one PS/2 line: the level only moves once FILTER_LEN samples agree.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic line_i,
    output logic level_o,
    output logic fall_edge_o
);

    logic [FILTER_LEN-1:0] sh_q;
    logic                  level_q;
    logic                  fall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q    <= '1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sh_q   <= {sh_q[FILTER_LEN-2:0], line_i};
            fall_q <= 1'b0;
            if (&sh_q) begin
                level_q <= 1'b1;
            end else if (~|sh_q) begin
                level_q <= 1'b0;
                fall_q  <= level_q;
            end
        end
    end

    assign level_o     = level_q;
    assign fall_edge_o = fall_q;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, device-clocked frame with odd parity,
// ACK check and a watchdog on the device clock.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int unsigned RTS_CYCLES     = 10000,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err_tick
);

    localparam int unsigned MAXC = (RTS_CYCLES > TIMEOUT_CYCLES) ? RTS_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAXC);
    localparam logic [CW-1:0] RTS_LAST = CW'(RTS_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_e state_q;
    logic [8:0]    frame_q;
    logic [3:0]    n_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;
    logic          done_q;
    logic          err_q;

    logic c_level, c_fall;
    logic d_level, ps2d_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
        .clk        (clk),
        .reset      (reset),
        .line_i     (ps2c),
        .level_o    (c_level),
        .fall_edge_o(c_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
        .clk        (clk),
        .reset      (reset),
        .line_i     (ps2d),
        .level_o    (d_level),
        .fall_edge_o(ps2d_fall_unused)
    );

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wr_ps2) begin
                        frame_q <= {odd_parity(din), din};
                        cnt_q   <= '0;
                        state_q <= ST_RTS;
                    end
                end
                ST_RTS: begin
                    if (cnt_q >= RTS_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_START;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    // Watchdog shared by every device-clocked state; a fall edge restarts it.
                    if (!c_fall && cnt_q >= TO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= c_fall ? '0 : cnt_inc;
                        case (state_q)
                            ST_START: begin
                                if (c_fall) begin
                                    n_q     <= 4'd8;
                                    state_q <= ST_DATA;
                                end
                            end
                            ST_DATA: begin
                                if (c_fall) begin
                                    if (n_q == 4'd0) begin
                                        state_q <= ST_STOP;
                                    end else begin
                                        frame_q <= {1'b0, frame_q[8:1]};
                                        n_q     <= n_q - 4'd1;
                                    end
                                end
                            end
                            ST_STOP: begin
                                if (c_fall) begin
                                    if (d_level) begin
                                        err_q   <= 1'b1;
                                        state_q <= ST_IDLE;
                                    end else begin
                                        state_q <= ST_WAIT;
                                    end
                                end
                            end
                            ST_WAIT: begin
                                if (c_level && d_level) begin
                                    done_q  <= 1'b1;
                                    state_q <= ST_IDLE;
                                end
                            end
                            default: state_q <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign ps2c = (state_q == ST_RTS) ? 1'b0 : 1'bz;
    assign ps2d = ((state_q == ST_START) || (state_q == ST_DATA && !frame_q[0])) ? 1'b0 : 1'bz;

    assign tx_idle      = (state_q == ST_IDLE);
    assign tx_done_tick = done_q;
    assign tx_err_tick  = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: behavioural keyboard on pulled-up lines, scoreboard of expected frames.
module tb_ps2_tx;

    localparam int unsigned RTS  = 20;
    localparam int unsigned FLT  = 4;
    localparam int unsigned TO   = 500;
    localparam int          HALF = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = '0;
    logic       tx_idle, tx_done_tick, tx_err_tick;
    logic       kb_c_low = 1'b0;
    logic       kb_d_low = 1'b0;
    wire        ps2c, ps2d;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = kb_c_low ? 1'b0 : 1'bz;
    assign ps2d = kb_d_low ? 1'b0 : 1'bz;

    ps2_tx #(
        .RTS_CYCLES    (RTS),
        .FILTER_LEN    (FLT),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_ps2      (wr_ps2),
        .din         (din),
        .ps2c        (ps2c),
        .ps2d        (ps2d),
        .tx_idle     (tx_idle),
        .tx_done_tick(tx_done_tick),
        .tx_err_tick (tx_err_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int err_cyc = 0, fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done_tick) done_cnt++;
        if (tx_err_tick) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (tx_done_tick && tx_err_tick) both_cnt++;
    end

    typedef struct {
        logic [7:0] din;
        bit         ack;
        int         edges;
        bit         exp_parity;
        bit         exp_done;
        bit         exp_err;
    } vec_t;

    typedef struct {
        logic [7:0] din;
        bit         par;
        bit         done;
        bit         err;
        bit         full;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue_wr(input logic [7:0] b);
        @(negedge clk);
        din    = b;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        din    = '0;
        check("accept_idle_low", {31'd0, tx_idle}, 32'd0);
        check("accept_rts_clk", {31'd0, ps2c}, 32'd0);
    endtask

    // Keyboard: samples each bit mid-way through the high phase before falls 1..11,
    // pulls data low ahead of fall 11 to acknowledge.
    task automatic run_kb(input bit ack, input int n_edges, output logic [10:0] bits, output bit ok);
        int w;
        bits = '1;
        ok   = 1'b1;
        w    = 0;
        while (ps2c !== 1'b1 && w < int'(RTS) + 100) begin
            @(negedge clk);
            w++;
        end
        if (ps2c !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        for (int k = 0; k < n_edges; k++) begin
            repeat (HALF / 2) @(negedge clk);
            bits[k] = ps2d;
            if (k == 10 && ack) begin
                repeat (HALF / 4) @(negedge clk);
                kb_d_low = 1'b1;
                repeat (HALF / 4) @(negedge clk);
            end else begin
                repeat (HALF / 2) @(negedge clk);
            end
            kb_c_low = 1'b1;
            fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            kb_c_low = 1'b0;
            kb_d_low = 1'b0;
        end
    endtask

    task automatic finish_txn(input int d0, input int e0, input logic [10:0] bits, input bit ok);
        exp_t e;
        int   w;
        check("kb_saw_release", {31'd0, ok}, 32'd1);
        w = 0;
        while (done_cnt == d0 && err_cnt == e0 && w < 800) begin
            @(negedge clk);
            w++;
        end
        repeat (5) @(negedge clk);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        if (e.full) begin
            check("start_bit", {31'd0, bits[0]}, 32'd0);
            check("data_bits", {24'd0, bits[8:1]}, {24'd0, e.din});
            check("parity_bit", {31'd0, bits[9]}, {31'd0, e.par});
            check("stop_bit", {31'd0, bits[10]}, 32'd1);
        end else begin
            check("timeout_latency",
                  {31'd0, (err_cyc - fall_cyc >= int'(TO)) && (err_cyc - fall_cyc <= int'(TO + FLT) + 10)},
                  32'd1);
        end
        check("done_ticks", done_cnt - d0, {31'd0, e.done});
        check("err_ticks", err_cnt - e0, {31'd0, e.err});
        check("idle_after", {31'd0, tx_idle}, 32'd1);
        check("ps2c_released", {31'd0, ps2c}, 32'd1);
        check("ps2d_released", {31'd0, ps2d}, 32'd1);
    endtask

    task automatic run_txn(input vec_t v);
        logic [10:0] bits;
        bit          ok;
        int          d0, e0;
        exp_t        e;
        d0 = done_cnt;
        e0 = err_cnt;
        e.din  = v.din;
        e.par  = v.exp_parity;
        e.done = v.exp_done;
        e.err  = v.exp_err;
        e.full = (v.edges == 11);
        sb.push_back(e);
        issue_wr(v.din);
        run_kb(v.ack, v.edges, bits, ok);
        finish_txn(d0, e0, bits, ok);
    endtask

    task automatic reset_pulse_check(input string tag);
        int d0, e0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check({tag, "_ps2c"}, {31'd0, ps2c}, 32'd1);
        check({tag, "_ps2d"}, {31'd0, ps2d}, 32'd1);
        check({tag, "_idle"}, {31'd0, tx_idle}, 32'd1);
        check({tag, "_ticks"}, {30'd0, tx_done_tick, tx_err_tick}, 32'd0);
        d0 = done_cnt;
        e0 = err_cnt;
        repeat (TO + 50) @(negedge clk);
        check({tag, "_no_late_ticks"}, (done_cnt - d0) + (err_cnt - e0), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        logic [10:0] bits;
        bit          ok;
        int          d0, e0;
        exp_t        e;

        vecs[0] = '{din: 8'hED, ack: 1'b1, edges: 11, exp_parity: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
        vecs[1] = '{din: 8'hFF, ack: 1'b1, edges: 11, exp_parity: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
        vecs[2] = '{din: 8'h00, ack: 1'b1, edges: 11, exp_parity: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
        vecs[3] = '{din: 8'h01, ack: 1'b1, edges: 11, exp_parity: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
        vecs[4] = '{din: 8'hED, ack: 1'b0, edges: 11, exp_parity: 1'b1, exp_done: 1'b0, exp_err: 1'b1};
        vecs[5] = '{din: 8'hA6, ack: 1'b1, edges: 4,  exp_parity: 1'b1, exp_done: 1'b0, exp_err: 1'b1};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_idle", {31'd0, tx_idle}, 32'd1);
        check("reset_done", {31'd0, tx_done_tick}, 32'd0);
        check("reset_err", {31'd0, tx_err_tick}, 32'd0);
        check("reset_ps2c", {31'd0, ps2c}, 32'd1);
        check("reset_ps2d", {31'd0, ps2d}, 32'd1);

        foreach (vecs[i]) run_txn(vecs[i]);

        // Write strobe in the middle of DATA must not disturb the frame in flight.
        d0 = done_cnt;
        e0 = err_cnt;
        e = '{din: 8'h3C, par: 1'b1, done: 1'b1, err: 1'b0, full: 1'b1};
        sb.push_back(e);
        issue_wr(8'h3C);
        fork
            run_kb(1'b1, 11, bits, ok);
            begin
                repeat (1500) @(negedge clk);
                check("busy_mid_data", {31'd0, tx_idle}, 32'd0);
                din    = 8'h55;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
                din    = '0;
            end
        join
        finish_txn(d0, e0, bits, ok);

        issue_wr(8'h5A);
        repeat (5) @(negedge clk);
        reset_pulse_check("rst_rts");

        issue_wr(8'hA5);
        run_kb(1'b1, 3, bits, ok);
        check("rst_data_kb_sync", {31'd0, ok}, 32'd1);
        reset_pulse_check("rst_data");

        run_txn('{din: 8'hFF, ack: 1'b1, edges: 11, exp_parity: 1'b1, exp_done: 1'b1, exp_err: 1'b0});

        check("ticks_exclusive", both_cnt, 32'd0);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/ps2_tx.md
# ps2_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xFF reset, 0xED set-LEDs) from the FPGA to the keyboard using the PS/2 request-to-send protocol, with device-generated clocking, odd parity and acknowledge checking. It sits beside the existing `ps2_rx` on the same open-drain `ps2c`/`ps2d` lines. `tx_idle` gates the receiver's `rx_en`, so the device's 0xFA reply is captured by the unchanged receive path.

## Interface
- `RTS_CYCLES`, 10000: cycles `ps2c` is held low for request-to-send (100 µs at 100 MHz).
- `FILTER_LEN`, 8: `ps2c`/`ps2d` glitch-filter length in cycles.
- `TIMEOUT_CYCLES`, 2000000: maximum cycles between device clock falling edges before abort (20 ms).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `wr_ps2`  in  1  one-cycle write strobe; accepted only when `tx_idle`=1.
- `din`  in  8  command byte, sampled with `wr_ps2`.
- `ps2c`  inout  1  PS/2 clock, open-drain: driven 0 or released (z).
- `ps2d`  inout  1  PS/2 data, open-drain: driven 0 or released (z).
- `tx_idle`  out  1  high when no transfer is in progress.
- `tx_done_tick`  out  1  one-cycle pulse: byte sent and device ACK received.
- `tx_err_tick`  out  1  one-cycle pulse: missing ACK or timeout.

## Operation
- Clock filter: `ps2c` is sampled into a FILTER_LEN shift register. The filtered level changes only when the register is all-0 or all-1. `fall_edge` is a one-cycle pulse on a filtered 1→0 transition. `ps2d` is filtered the same way for ACK sampling.
- Frame register: 9 bits {parity, din}, loaded on an accepted `wr_ps2`. Odd parity: parity = ~^din.
- FSM states and transitions:
  - IDLE: lines released, `tx_idle`=1. On `wr_ps2`: load frame, clear counter, go to RTS.
  - RTS: drive `ps2c` low, `ps2d` released. After RTS_CYCLES, go to START.
  - START: `ps2c` released, `ps2d` driven 0 (start bit). On `fall_edge`: set n=8, go to DATA.
  - DATA: `ps2d` = frame[0] (0 → drive low, 1 → release). On `fall_edge`: if n=0 go to STOP; else shift frame right and decrement n. Falling edges 1–9 present d0..d7 then parity.
  - STOP: both lines released (stop bit = 1). On `fall_edge` (edge 11), sample filtered `ps2d`: if 0, go to WAIT; if 1, pulse `tx_err_tick` and go to IDLE.
  - WAIT: wait until filtered `ps2c` and `ps2d` are both 1, then pulse `tx_done_tick` and go to IDLE.
- Watchdog: in START, DATA, STOP and WAIT, the counter increments each cycle and clears on `fall_edge`. Reaching TIMEOUT_CYCLES releases both lines, pulses `tx_err_tick` and returns to IDLE.
- `wr_ps2` while busy: ignored. No queueing and no error.
- Reset, including mid-transfer: FSM goes to IDLE, both lines are released on the cycle after `reset` is sampled, ticks are 0, and `tx_idle`=1.
- Counter width is $clog2(max(RTS_CYCLES, TIMEOUT_CYCLES)+1). The counter saturates and never wraps.

## Timing
- Reset values: `tx_idle`=1, `tx_done_tick`=0, `tx_err_tick`=0, `ps2c`/`ps2d` = z, filters preset to all-1.
- Accepted `wr_ps2` at cycle t: `tx_idle`=0 and `ps2c` low from t+1. `ps2d` goes low and `ps2c` is released at t+1+RTS_CYCLES.
- Data update lag: at most FILTER_LEN+2 cycles after the raw `ps2c` fall. This is well inside the device's ≥30 µs low phase.
- Drive enables decode directly from registered state and frame bit. They are glitch-free, with no combinational path from inputs.
- `tx_done_tick` fires FILTER_LEN+1 cycles after both raw lines rise following the ACK. `tx_idle` returns to 1 in the same cycle.
- `tx_done_tick` and `tx_err_tick` are never both high.

## Structure
- Package `ps2_pkg`:
  - state enum for the FSM;
  - `PS2_CMD_RESET`=8'hFF, `PS2_CMD_SET_LEDS`=8'hED, `PS2_ACK`=8'hFA.
- Sub-module `ps2_line_filter` (FILTER_LEN): filtered level plus `fall_edge`, instantiated for `ps2c` and `ps2d`. It is reusable by `ps2_rx`.
- The top-level keyboard wrapper ties `rx_en` to `tx_idle`.

## Test plan
Bench uses RTS_CYCLES=20, FILTER_LEN=4, TIMEOUT_CYCLES=500, and a keyboard model that clocks at 200-cycle half-periods.
- `din`=8'hED: device samples start 0, bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1; model ACKs 0 → one `tx_done_tick`, no error, `tx_idle`=1.
- `din`=8'hFF: parity bit is 1; `din`=8'h00: parity bit is 1; `din`=8'h01: parity bit is 0. Each must match the model's check.
- Model withholds ACK (`ps2d` stays 1 at edge 11) → `tx_err_tick` pulse, lines released, back to IDLE.
- Model stops clocking after edge 4 → `tx_err_tick` 500 cycles after the last edge; `ps2c`/`ps2d` = z.
- `wr_ps2` pulsed mid-DATA with `din`=8'h55 → ignored; the original byte completes unchanged.
- `reset` asserted during RTS and during DATA → lines released next cycle, `tx_idle`=1, no ticks; a following `wr_ps2` of 8'hFF completes normally.
